// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline hazard-control constants: state encoding, register-field width,
// default multiply/divide latency and the busy-counter width.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned MULDIV_LAT_DEF = 4;
    localparam int unsigned CNT_W          = 4;

    localparam logic [0:0] HZ_RUN  = 1'b0;
    localparam logic [0:0] HZ_BUSY = 1'b1;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_lu_detect.sv
// Load-use compare: the load in EX writes a register that the ID instruction reads.
// Register 0 is hardwired, so a load targeting it never creates a dependency.
module hazard_lu_detect
    import hazard_ctrl_pkg::*;
(
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  lu
);

    // Purely combinational dependency check
    always_comb begin
        lu = mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule : hazard_lu_detect

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing for PC, IF/ID and ID/EX.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] IFID_Rs_In,
    input  logic [REG_ADDR_W-1:0] IFID_Rt_In,
    input  logic                  IDEX_MemRead_In,
    input  logic [REG_ADDR_W-1:0] IDEX_Rt_In,
    input  logic                  Jump_In,
    input  logic                  Branch_Taken_In,
    input  logic                  MulDiv_Start_In,
    output logic                  PC_WriteEnable_Out,
    output logic                  IFID_WriteEnable_Out,
    output logic                  IFID_Flush_Out,
    output logic                  IDEX_WriteEnable_Out,
    output logic                  IDEX_Flush_Out,
    output logic                  EXMEM_Bubble_Out,
    output logic                  MulDiv_Busy_Out
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           Stall_Cycles_Out,
    output logic [31:0]           Flush_Count_Out
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 2);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ret_q, ret_d;
    logic             lu;

    hazard_lu_detect u_lu_detect (
        .mem_read (IDEX_MemRead_In),
        .ex_rt    (IDEX_Rt_In),
        .id_rs    (IFID_Rs_In),
        .id_rt    (IFID_Rt_In),
        .lu       (lu)
    );

    // State, busy counter and return-cycle flag
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
            ret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    // Next state and Mealy control outputs, first matching hazard wins
    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        ret_d                = 1'b0;
        PC_WriteEnable_Out   = 1'b1;
        IFID_WriteEnable_Out = 1'b1;
        IFID_Flush_Out       = 1'b0;
        IDEX_WriteEnable_Out = 1'b1;
        IDEX_Flush_Out       = 1'b0;
        EXMEM_Bubble_Out     = 1'b0;
        MulDiv_Busy_Out      = 1'b0;

        if (state_q == HZ_BUSY) begin
            PC_WriteEnable_Out   = 1'b0;
            IFID_WriteEnable_Out = 1'b0;
            IDEX_WriteEnable_Out = 1'b0;
            EXMEM_Bubble_Out     = 1'b1;
            MulDiv_Busy_Out      = 1'b1;
            if (cnt_q == '0) begin
                state_d = HZ_RUN;
                ret_d   = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (Branch_Taken_In) begin
            IFID_Flush_Out = 1'b1;
            IDEX_Flush_Out = 1'b1;
        end else if (MulDiv_Start_In) begin
            PC_WriteEnable_Out   = 1'b0;
            IFID_WriteEnable_Out = 1'b0;
            IDEX_WriteEnable_Out = 1'b0;
            // the previous mul/div result is still captured in its return cycle
            EXMEM_Bubble_Out     = !ret_q;
            state_d              = HZ_BUSY;
            cnt_d                = CNT_LOAD;
        end else if (lu) begin
            PC_WriteEnable_Out   = 1'b0;
            IFID_WriteEnable_Out = 1'b0;
            IDEX_Flush_Out       = 1'b1;
        end else if (Jump_In) begin
            IFID_Flush_Out = 1'b1;
        end

        // reset holds every stage register frozen and squashed
        if (!Reset) begin
            PC_WriteEnable_Out   = 1'b0;
            IFID_WriteEnable_Out = 1'b0;
            IDEX_WriteEnable_Out = 1'b0;
            IFID_Flush_Out       = 1'b1;
            IDEX_Flush_Out       = 1'b1;
            EXMEM_Bubble_Out     = 1'b0;
            MulDiv_Busy_Out      = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating stall and flush event counters
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Stall_Cycles_Out <= '0;
            Flush_Count_Out  <= '0;
        end else begin
            if (!PC_WriteEnable_Out && (Stall_Cycles_Out != '1)) begin
                Stall_Cycles_Out <= Stall_Cycles_Out + 32'd1;
            end
            if (IFID_Flush_Out && (Flush_Count_Out != '1)) begin
                Flush_Count_Out <= Flush_Count_Out + 32'd1;
            end
        end
    end
`endif

endmodule : hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the stall (WriteEnable) and squash (Flush) controls of the PC, IF/ID and ID/EX stage registers. It sits beside the ID stage and consumes decoded register fields from IF/ID plus control bits coming out of ID/EX. It detects load-use hazards, taken branches, ID-stage jumps and multi-cycle multiply/divide occupancy of EX. From these it sequences bubbles, freezes and flushes so the downstream stage registers only ever see legal control.

## Interface
Parameters:
- MULDIV_LAT, 4, total EX cycles of a multiply/divide; legal range 2..16.

Ports:
- Clock  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- IFID_Rs_In  in  5  rs field of the instruction in ID.
- IFID_Rt_In  in  5  rt field of the instruction in ID.
- IDEX_MemRead_In  in  1  the instruction in EX is a load.
- IDEX_Rt_In  in  5  destination rt of the instruction in EX.
- Jump_In  in  1  the ID-stage instruction is a jump.
- Branch_Taken_In  in  1  branch resolved taken in EX this cycle.
- MulDiv_Start_In  in  1  the EX instruction is a multiply/divide; valid in its first EX cycle only.
- PC_WriteEnable_Out  out  1  PC update enable.
- IFID_WriteEnable_Out  out  1  IF/ID capture enable.
- IFID_Flush_Out  out  1  IF/ID squash.
- IDEX_WriteEnable_Out  out  1  ID/EX capture enable.
- IDEX_Flush_Out  out  1  ID/EX squash (inserts a bubble).
- EXMEM_Bubble_Out  out  1  EX result is invalid this cycle; EX/MEM captures a bubble.
- MulDiv_Busy_Out  out  1  the controller is in state BUSY.

## Operation
- States: RUN and BUSY. A 4-bit down-counter `cnt` is used in BUSY.
- Load-use hazard `lu` is true when all of the following hold:
  - IDEX_MemRead_In is 1.
  - IDEX_Rt_In is not 0.
  - IDEX_Rt_In equals IFID_Rs_In or IFID_Rt_In.
- Outputs in RUN, evaluated combinationally from state and inputs. The first matching rule wins:
  - Branch_Taken_In: IFID_Flush=1, IDEX_Flush=1, all write enables=1. Jump_In and lu are ignored.
  - MulDiv_Start_In: PC_WE=0, IFID_WE=0, IDEX_WE=0, EXMEM_Bubble=1. The controller moves to BUSY with cnt=MULDIV_LAT-2.
  - lu: PC_WE=0, IFID_WE=0, IDEX_Flush=1, IDEX_WE=1. This is exactly one bubble; the next cycle re-evaluates.
  - Jump_In: IFID_Flush=1, all write enables=1.
  - None: all write enables=1, both flushes=0, EXMEM_Bubble=0.
- Outputs in BUSY: PC_WE=0, IFID_WE=0, IDEX_WE=0, EXMEM_Bubble=1, flushes=0, MulDiv_Busy=1.
  - cnt decrements every cycle.
  - When cnt==0, the controller returns to RUN at the next edge.
  - In that RUN cycle EXMEM_Bubble=0 and the result is captured.
- In BUSY, Branch_Taken_In, Jump_In, lu and MulDiv_Start_In are ignored.
  - The occupying instruction cannot be a branch.
  - Hazards pending in ID are re-evaluated after return to RUN.
- Flush and WriteEnable on the same stage register are both asserted during a taken branch. This is legal because the register gives Flush priority.
- While Reset is low:
  - State is RUN and cnt is 0.
  - All write-enable outputs are 0.
  - IFID_Flush_Out and IDEX_Flush_Out are 1.
  - EXMEM_Bubble_Out and MulDiv_Busy_Out are 0.
- Reset asserted mid-BUSY aborts the operation. After release the controller is in RUN with no residual stall.

## Timing
- Decision outputs are Mealy and valid in the same cycle as their causing inputs. There is no added latency.
- Load-use costs exactly 1 stall cycle.
- A taken branch costs 2 squashed slots; a jump costs 1 squashed slot.
- Multiply/divide holds the front end for exactly MULDIV_LAT cycles, counting the start cycle. Front-end write enables return to 1 in cycle MULDIV_LAT+1.
- Back-to-back multiply/divide instructions re-enter BUSY immediately in the return cycle with no gap.

## Configuration
- HAZARD_PERF_CNT_EN defined adds two outputs, both cleared by Reset:
  - Stall_Cycles_Out[31:0]: increments on every cycle in which PC_WriteEnable_Out=0 while Reset is high.
  - Flush_Count_Out[31:0]: increments on every cycle with IFID_Flush_Out=1 while Reset is high.
  - Both counters saturate at 32'hFFFFFFFF.
- HAZARD_PERF_CNT_EN undefined: the ports and counters are absent and the stall/flush behaviour is identical.

## Structure
- Shared pipeline package holds:
  - the state encoding constants HZ_RUN=1'b0 and HZ_BUSY=1'b1;
  - the register-field width constant REG_ADDR_W=5;
  - the default MULDIV_LAT.
- One sub-module, hazard_lu_detect: purely combinational compare producing lu. It is reused by the forwarding unit.
- The FSM, counter and output priority logic stay in hazard_ctrl.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for 1 cycle -> PC_WE=0, IFID_WE=0, IDEX_Flush=1 for exactly that cycle. With IDEX_Rt=0 there must be no stall.
- Branch with concurrent load-use and jump: Branch_Taken=1 together with lu=1 and Jump_In=1 -> IFID_Flush=1, IDEX_Flush=1, PC_WE=1, no stall.
- MULDIV_LAT=4: single start pulse -> EXMEM_Bubble=1 and front end frozen for 4 cycles, MulDiv_Busy=1 for cycles 2-4, all enables 1 in cycle 5.
- Back-to-back multiply/divide: second MulDiv_Start in the return cycle -> 8 consecutive frozen cycles, with EXMEM_Bubble=0 only in cycle 5.
- Reset low during BUSY cycle 2:
  - during reset, WE=0 and flushes=1;
  - after release, RUN with all enables 1;
  - no leftover busy cycles.
- HAZARD_PERF_CNT_EN: 1 load-use, 1 jump and 1 MULDIV_LAT=4 operation -> Stall_Cycles_Out=5, Flush_Count_Out=1.
